sdram_pattern_checker: RTL
==========================

# sdram_pattern_checker

Self-checking SDRAM traffic engine that drives the request FIFO of the `sdram` controller with a write sweep over a parametrised address range, then reads the same range back through the response FIFO and compares each word against a regenerated pattern. It is the synthesizable, parametrised successor to the hand-written write/read-back bench stimulus. It adds selectable data patterns, error counting and capture, looped soak passes and abort. It sits between the `fifo_sync` request/response pair and a status/debug register block.

## Interface
- `ADDR_W`, 24, address field width: bank plus row plus column.
- `DATA_W`, 16, data field width.
- `START_ADDR`, 0, first address of the sweep.
- `LAST_ADDR`, 3, last address of the sweep, inclusive; must be >= `START_ADDR`.
- `LFSR_TAPS`, 16'hB400, Galois LFSR feedback mask (`DATA_W` bits).
- `LFSR_SEED`, 1, LFSR start value; must be nonzero.
- `ERR_W`, 16, error counter width.
- `clk_48` in 1: sole clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin run; sampled in IDLE only.
- `abort` in 1: stop the run early.
- `loop` in 1: repeat passes while high.
- `mode` in 2: pattern select, latched on start.
  - 0: `addr[DATA_W-1:0]`
  - 1: `~addr[DATA_W-1:0]`
  - 2: LFSR
  - 3: treated as 0
- `req_data` out `1+ADDR_W+DATA_W`: request word `{rw, addr, data}`; rw=1 write, rw=0 read with zero data.
- `req_write` out 1: request FIFO write strobe.
- `req_full` in 1: request FIFO full.
- `rsp_data` in `1+ADDR_W+DATA_W`: response FIFO head word, first-word fall-through, valid while `rsp_empty`=0.
- `rsp_read` out 1: response FIFO pop strobe.
- `rsp_empty` in 1: response FIFO empty.
- `busy` out 1: run in progress.
- `done` out 1: last run completed without abort; held until next start.
- `pass` out 1: valid with `done`; err_count==0.
- `err_count` out `ERR_W`: mismatches in current run; saturating.
- `first_err_addr` out `ADDR_W`: address of first mismatch.
- `first_err_data` out `DATA_W`: data read at first mismatch.
- `pass_count` out 16: completed passes in current run; wraps.

## Operation
- States: IDLE, WR_REQ, WR_ACK, RD_REQ, RD_ACK. Exactly one request outstanding at any time.
- IDLE + `start` → WR_REQ:
  - addr=`START_ADDR`, LFSR=`LFSR_SEED`, latch `mode`.
  - Clear `err_count`, `first_err_*`, `pass_count`, `done`, `pass`.
  - Set `busy`.
- WR_REQ:
  - If `req_full`=0: `req_data`←{1, addr, pattern}, `req_write`←1 for one cycle, → WR_ACK.
  - Otherwise hold with `req_write`=0.
- WR_ACK:
  - If `rsp_empty`=0: `rsp_read`←1 for one cycle; write response contents are ignored.
  - If addr==`LAST_ADDR`: addr←`START_ADDR`, LFSR←seed, → RD_REQ.
  - Else: addr+1, LFSR step, → WR_REQ.
- RD_REQ: as WR_REQ with rw=0 and data=0, → RD_ACK.
- RD_ACK, when `rsp_empty`=0:
  - Pop the response and compare `rsp_data[DATA_W-1:0]` with the expected pattern.
  - On mismatch: `err_count`+1, saturating at all-ones. If `err_count` was 0, capture `first_err_addr`/`first_err_data`.
  - If addr≠`LAST_ADDR`: addr+1, LFSR step, → RD_REQ.
  - At `LAST_ADDR`: `pass_count`+1. If `loop`=1: addr/LFSR reload, → WR_REQ. Else: `done`←1, `pass`←(final err_count==0), `busy`←0, → IDLE.
- Pass semantics: `err_count` accumulates over all passes of a run; `pass` reflects the whole run.
- LFSR step: `lfsr = lfsr[0] ? (lfsr>>1)^LFSR_TAPS : lfsr>>1`. Read phase regenerates the identical sequence from the seed.
- Address compare happens before increment, so `LAST_ADDR`=all-ones never wraps. `START_ADDR`==`LAST_ADDR` gives a one-word sweep.
- `abort`:
  - In WR_REQ/RD_REQ: → IDLE next cycle; no request issued that cycle.
  - In WR_ACK/RD_ACK: latched; the outstanding response is still popped (and compared in RD_ACK), then → IDLE.
  - After abort: `done`=0, `busy`=0, counters hold.
- `start` while busy: ignored.

## Timing
- Reset values: all outputs 0, including `req_data`, `first_err_*` and `pass_count`. State IDLE.
- Reset mid-run: immediate return to IDLE; FIFO contents are the integrator's responsibility.
- All outputs registered.
- Strobes:
  - `req_write` is high exactly one cycle per request, with `req_data` stable that cycle.
  - `rsp_read` is high exactly one cycle per response, in the cycle the head word is consumed.
- Minimum per word: 2 cycles, request then pop when the response is already present.
- No back-to-back strobes of the same kind: ≥1 idle cycle between, so the FIFO empty flag can update.
- `done`/`pass`/`err_count` are updated in the same edge as the final pop.
- `busy` rises the cycle after `start` and falls the cycle after the final pop.

## Test plan
- Mode 0, range 0..3, loopback model echoing data:
  - Requests in order: writes data 0,1,2,3, then reads addr 0..3.
  - Result: `done`=1, `pass`=1, `err_count`=0, `pass_count`=1.
- Mode 2, memory model forcing read data 16'hFFFF at addr 2 only:
  - `err_count`=1, `first_err_addr`=2, `first_err_data`=16'hFFFF, `pass`=0.
- `req_full` held high 10 cycles mid-write:
  - No `req_write` during that window.
  - Sequence resumes with no lost or duplicated address.
- `loop`=1 for 3 passes, then drop `loop`:
  - `pass_count`=3, `busy` stays high between passes, then `done`=1.
- `abort` asserted in RD_ACK with the response delayed 5 cycles:
  - Response still popped exactly once, then IDLE with `done`=0.
  - A subsequent `start` restarts at `START_ADDR`.
- `rst` pulsed mid-write:
  - All outputs 0 within the same cycle (asynchronous).
  - A new `start` runs a clean pass.

Source files
------------

// File: rtl/sdram_pattern_checker.sv
// ---------------------------------------------------------------------------
// sdram_pattern_checker
//
// Self-checking SDRAM traffic engine. A run writes a data pattern over the
// address range START_ADDR..LAST_ADDR through the request FIFO, then reads
// the same range back through the response FIFO. Each read word is compared
// against the regenerated pattern. With i_loop held high, the write/read
// passes repeat. Errors accumulate across all passes of a run.
//
// Only one request is outstanding at a time. Every output is registered.
// The address field is assumed to be at least as wide as the data field,
// because the address patterns take the low DATA_W bits of the address.
//
// Ports
//   i_clk_48          : sole clock, rising edge
//   i_rst             : asynchronous active-high reset
//   i_start           : begin a run (sampled in IDLE only)
//   i_abort           : stop the run early
//   i_loop            : repeat passes while high
//   i_mode            : pattern select, latched on start
//                       (0 addr, 1 ~addr, 2 LFSR, 3 addr)
//   o_req_data        : request word {rw, addr, data}; rw=1 means write
//   o_req_write       : request FIFO write strobe
//   i_req_full        : request FIFO full
//   i_rsp_data        : response FIFO head word (first-word fall-through)
//   o_rsp_read        : response FIFO pop strobe
//   i_rsp_empty       : response FIFO empty
//   o_busy            : run in progress
//   o_done            : last run finished without abort
//   o_pass            : with o_done, high when no mismatch was seen
//   o_err_count       : saturating mismatch count for the current run
//   o_first_err_addr  : address of the first mismatch
//   o_first_err_data  : data read at the first mismatch
//   o_pass_count      : passes completed in the current run (wraps)
// ---------------------------------------------------------------------------
module sdram_pattern_checker #(
    parameter int                ADDR_W     = 24,
    parameter int                DATA_W     = 16,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(3),
    parameter logic [DATA_W-1:0] LFSR_TAPS  = 16'hB400,
    parameter logic [DATA_W-1:0] LFSR_SEED  = DATA_W'(1),
    parameter int                ERR_W      = 16
) (
    input  logic                     i_clk_48,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic                     i_loop,
    input  logic [1:0]               i_mode,
    output logic [ADDR_W+DATA_W:0]   o_req_data,
    output logic                     o_req_write,
    input  logic                     i_req_full,
    input  logic [ADDR_W+DATA_W:0]   i_rsp_data,
    output logic                     o_rsp_read,
    input  logic                     i_rsp_empty,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_pass,
    output logic [ERR_W-1:0]         o_err_count,
    output logic [ADDR_W-1:0]        o_first_err_addr,
    output logic [DATA_W-1:0]        o_first_err_data,
    output logic [15:0]              o_pass_count
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_ACK,
        RD_REQ,
        RD_ACK
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_lfsr;
    logic [1:0]          r_mode;
    logic                r_abort;   // abort seen while a response is pending

    logic [DATA_W-1:0]   w_pattern;
    logic [DATA_W-1:0]   w_lfsr_next;
    logic                w_last;
    logic                w_mismatch;
    logic                w_abort;
    logic [ERR_W-1:0]    w_err_next;
    logic                w_unused;

    // Expected data for the current address, used both when writing and
    // when checking read data.
    always_comb begin
        w_pattern = r_addr[DATA_W-1:0];
        case (r_mode)
            2'd1:    w_pattern = ~r_addr[DATA_W-1:0];
            2'd2:    w_pattern = r_lfsr;
            default: w_pattern = r_addr[DATA_W-1:0];
        endcase
    end

    // Galois LFSR step. The read phase reloads the seed, so it walks the
    // same sequence that the write phase walked.
    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);

    // The address is compared before it is incremented, so an all-ones
    // LAST_ADDR ends the sweep without wrapping.
    assign w_last     = (r_addr == LAST_ADDR);
    assign w_mismatch = (i_rsp_data[DATA_W-1:0] != w_pattern);
    assign w_abort    = i_abort | r_abort;
    assign w_err_next = (w_mismatch && (o_err_count != '1)) ? o_err_count + 1'b1
                                                             : o_err_count;

    // The rw and address fields of the response are not checked.
    assign w_unused = &{1'b0, i_rsp_data[ADDR_W+DATA_W:DATA_W]};

    always_ff @(posedge i_clk_48 or posedge i_rst) begin
        if (i_rst) begin
            r_state          <= IDLE;
            r_addr           <= '0;
            r_lfsr           <= '0;
            r_mode           <= '0;
            r_abort          <= 1'b0;
            o_req_data       <= '0;
            o_req_write      <= 1'b0;
            o_rsp_read       <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_pass           <= 1'b0;
            o_err_count      <= '0;
            o_first_err_addr <= '0;
            o_first_err_data <= '0;
            o_pass_count     <= '0;
        end else begin
            // Both strobes are single-cycle pulses. The earliest next strobe
            // of the same kind comes two edges later, which leaves the FIFO
            // flags time to update.
            o_req_write <= 1'b0;
            o_rsp_read  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_addr           <= START_ADDR;
                        r_lfsr           <= LFSR_SEED;
                        r_mode           <= i_mode;
                        r_abort          <= 1'b0;
                        o_err_count      <= '0;
                        o_first_err_addr <= '0;
                        o_first_err_data <= '0;
                        o_pass_count     <= '0;
                        o_done           <= 1'b0;
                        o_pass           <= 1'b0;
                        o_busy           <= 1'b1;
                        r_state          <= WR_REQ;
                    end
                end

                WR_REQ, RD_REQ: begin
                    if (i_abort) begin
                        o_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (!i_req_full) begin
                        o_req_write <= 1'b1;
                        if (r_state == WR_REQ) begin
                            o_req_data <= {1'b1, r_addr, w_pattern};
                            r_state    <= WR_ACK;
                        end else begin
                            o_req_data <= {1'b0, r_addr, {DATA_W{1'b0}}};
                            r_state    <= RD_ACK;
                        end
                    end
                end

                WR_ACK: begin
                    if (!i_rsp_empty) begin
                        o_rsp_read <= 1'b1;
                        if (w_abort) begin
                            o_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else if (w_last) begin
                            r_addr  <= START_ADDR;
                            r_lfsr  <= LFSR_SEED;
                            r_state <= RD_REQ;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_lfsr  <= w_lfsr_next;
                            r_state <= WR_REQ;
                        end
                    end else if (i_abort) begin
                        r_abort <= 1'b1;
                    end
                end

                RD_ACK: begin
                    if (!i_rsp_empty) begin
                        o_rsp_read  <= 1'b1;
                        o_err_count <= w_err_next;
                        if (w_mismatch && (o_err_count == '0)) begin
                            o_first_err_addr <= r_addr;
                            o_first_err_data <= i_rsp_data[DATA_W-1:0];
                        end
                        if (w_abort) begin
                            o_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else if (!w_last) begin
                            r_addr  <= r_addr + 1'b1;
                            r_lfsr  <= w_lfsr_next;
                            r_state <= RD_REQ;
                        end else begin
                            o_pass_count <= o_pass_count + 1'b1;
                            if (i_loop) begin
                                r_addr  <= START_ADDR;
                                r_lfsr  <= LFSR_SEED;
                                r_state <= WR_REQ;
                            end else begin
                                o_done  <= 1'b1;
                                o_pass  <= (w_err_next == '0);
                                o_busy  <= 1'b0;
                                r_state <= IDLE;
                            end
                        end
                    end else if (i_abort) begin
                        r_abort <= 1'b1;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
